uart_rx_q: RTL

Parametrised successor to the single-byte UART receiver.
- Configurable character width, optional parity, and a run-time baud divisor.
- Start-bit validation and framing/parity error detection.
- Per-entry error tagging, stored in a first-word-fall-through receive queue of parametrised depth, plus a sticky overrun flag.
- Sits between the RX pad and the bus-interface/SPART register block; the bus reads data and status through a pop handshake.

---
 rtl/uart_pkg.sv | 36 +++
 rtl/uart_rx_fifo.sv | 46 ++++
 rtl/uart_rx_q.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types for the UART receive path: parity modes, receiver FSM states
// and the queue entry layout.
package uart_pkg;

    localparam int RX_DATA_W_MAX = 9;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_t;

    typedef logic [2:0] rx_state_t;

    localparam rx_state_t IDLE   = 3'd0;
    localparam rx_state_t START  = 3'd1;
    localparam rx_state_t DATA   = 3'd2;
    localparam rx_state_t PARITY = 3'd3;
    localparam rx_state_t STOP   = 3'd4;

    typedef struct packed {
        logic                     par_err;
        logic                     frame_err;
        logic [RX_DATA_W_MAX-1:0] data;
    } rx_entry_t;

    // Encoding 3 is reserved and behaves as "no parity".
    function automatic parity_t decode_parity(input logic [1:0] mode);
        case (mode)
            2'd1:    return PAR_EVEN;
            2'd2:    return PAR_ODD;
            default: return PAR_NONE;
        endcase
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through synchronous FIFO; a pop in the same cycle frees the
// slot so a push against a full queue is still accepted.
module uart_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             do_pop;
    logic             do_push;

    assign count    = wptr - rptr;
    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(DEPTH));
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + (AW+1)'(1);
            if (do_pop)  rptr <= rptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/uart_rx_q.sv
// UART receiver with run-time baud divisor and optional parity, feeding a
// FWFT queue of error-tagged characters with a sticky overrun flag.
//
// state  | meaning
// IDLE   | waiting for synchronised RX low
// START  | half-bit wait, then confirm start bit is still low
// DATA   | sampling DATA_W bits, LSB first
// PARITY | sampling the parity bit
// STOP   | sampling the stop bit, pushing the entry on the sample cycle
module uart_rx_q
    import uart_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int DIV_W  = 13
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   RX,
    input  logic [DIV_W-1:0]       baud_div,
    input  logic [1:0]             parity_mode,
    input  logic                   rd_en,
    input  logic                   clr_err,
    output logic [DATA_W-1:0]      rd_data,
    output logic                   rd_frame_err,
    output logic                   rd_par_err,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overrun,
    output logic                   busy
);
    logic             rx_s1;
    logic             rx_s2;
    rx_state_t        state;
    logic [DIV_W-1:0] baud_cnt;
    logic [DIV_W-1:0] div_q;
    parity_t          par_q;
    logic [3:0]       bit_cnt;
    logic [DATA_W-1:0] shreg;
    logic             par_err_q;
    logic             baud_tick;
    logic             push;
    rx_entry_t        push_entry;
    rx_entry_t        head;
    logic             head_unused;

    assign baud_tick = (baud_cnt == '0);
    assign busy      = (state != IDLE);
    assign push      = (state == STOP) && baud_tick;

    assign push_entry.par_err   = par_err_q;
    assign push_entry.frame_err = ~rx_s2;
    assign push_entry.data      = RX_DATA_W_MAX'(shreg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
        end else begin
            rx_s1 <= RX;
            rx_s2 <= rx_s1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            div_q     <= '0;
            par_q     <= PAR_NONE;
            bit_cnt   <= '0;
            shreg     <= '0;
            par_err_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!rx_s2) begin
                        state     <= START;
                        div_q     <= baud_div;
                        par_q     <= decode_parity(parity_mode);
                        baud_cnt  <= baud_div >> 1;
                        par_err_q <= 1'b0;
                    end
                end
                START: begin
                    if (!baud_tick) begin
                        baud_cnt <= baud_cnt - DIV_W'(1);
                    end else if (rx_s2) begin
                        state <= IDLE;
                    end else begin
                        state    <= DATA;
                        bit_cnt  <= '0;
                        baud_cnt <= div_q - DIV_W'(1);
                    end
                end
                DATA: begin
                    if (!baud_tick) begin
                        baud_cnt <= baud_cnt - DIV_W'(1);
                    end else begin
                        shreg    <= {rx_s2, shreg[DATA_W-1:1]};
                        baud_cnt <= div_q - DIV_W'(1);
                        bit_cnt  <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'(DATA_W - 1))
                            state <= (par_q == PAR_NONE) ? STOP : PARITY;
                    end
                end
                PARITY: begin
                    if (!baud_tick) begin
                        baud_cnt <= baud_cnt - DIV_W'(1);
                    end else begin
                        par_err_q <= (^shreg) ^ rx_s2 ^ (par_q == PAR_ODD);
                        baud_cnt  <= div_q - DIV_W'(1);
                        state     <= STOP;
                    end
                end
                STOP: begin
                    if (!baud_tick) baud_cnt <= baud_cnt - DIV_W'(1);
                    else            state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Setting wins over clearing so a drop in the clear cycle is not lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                        overrun <= 1'b0;
        else if (push && full && !rd_en)   overrun <= 1'b1;
        else if (clr_err)                  overrun <= 1'b0;
    end

    uart_rx_fifo #(
        .WIDTH ($bits(rx_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_entry),
        .pop       (rd_en),
        .pop_data  (head),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    assign rd_data      = head.data[DATA_W-1:0];
    assign rd_frame_err = head.frame_err;
    assign rd_par_err   = head.par_err;
    // Data bits above DATA_W are always stored as zero.
    assign head_unused  = ^head.data;

endmodule
